// File: rtl/reg_block_pkg.sv
// Shared constants and types for the operand-fetch / execute slice.
package reg_block_pkg;

  localparam int RWIDTH = 6;
  localparam int DWIDTH = 32;
  localparam int IMM_IN = 15;

  typedef logic [DWIDTH-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLT   = 4'd9,
    ALU_SLTU  = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_t;

endpackage

// File: rtl/reg_file.sv
// 2-read / 1-write register file with combinational reads and entry 0 tied to zero.
module reg_file
  import reg_block_pkg::*;
#(
  parameter int AW = RWIDTH,
  parameter int DW = DWIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          we,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  localparam int NREGS = 2 ** AW;

  logic [DW-1:0] mem [NREGS];

  // Reset clears every entry so no unwritten register can ever read as X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // No write bypass: a same-cycle write becomes visible only after the edge.
  assign rdata_a = (ra == '0) ? '0 : mem[ra];
  assign rdata_b = (rb == '0) ? '0 : mem[rb];

endmodule

// File: rtl/reg_block.sv
// Operand fetch and execute: register file, immediate/register operand-B mux, combinational ALU.
module reg_block #(
  parameter int RWIDTH = reg_block_pkg::RWIDTH,
  parameter int DWIDTH = reg_block_pkg::DWIDTH,
  parameter int IMM_IN = reg_block_pkg::IMM_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RWIDTH-1:0] rs,
  input  logic [RWIDTH-1:0] rt,
  input  logic [RWIDTH-1:0] rd,
  input  logic [DWIDTH-1:0] wd,
  input  logic              we,
  input  logic              muxsel1,
  input  logic [IMM_IN-1:0] imm_in,
  input  logic [3:0]        ALUopsel,
  output logic [DWIDTH-1:0] opBwd,
  output logic [DWIDTH-1:0] ALUresult
);

  logic signed [DWIDTH-1:0] op_a;
  logic signed [DWIDTH-1:0] op_b;
  logic signed [DWIDTH-1:0] rt_data;
  logic signed [DWIDTH-1:0] imm_ext;

  function automatic logic signed [DWIDTH-1:0] sign_ext(input logic [IMM_IN-1:0] imm);
    return {{(DWIDTH-IMM_IN){imm[IMM_IN-1]}}, imm};
  endfunction

  // Shift amount comes from the low five bits of operand B; no flags are produced.
  function automatic logic [DWIDTH-1:0] alu(input logic [3:0] op,
                                            input logic signed [DWIDTH-1:0] a,
                                            input logic signed [DWIDTH-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (reg_block_pkg::alu_op_t'(op))
      reg_block_pkg::ALU_ADD:   return a + b;
      reg_block_pkg::ALU_SUB:   return a - b;
      reg_block_pkg::ALU_AND:   return a & b;
      reg_block_pkg::ALU_OR:    return a | b;
      reg_block_pkg::ALU_XOR:   return a ^ b;
      reg_block_pkg::ALU_NOR:   return ~(a | b);
      reg_block_pkg::ALU_SLL:   return a << sh;
      reg_block_pkg::ALU_SRL:   return a >> sh;
      reg_block_pkg::ALU_SRA:   return a >>> sh;
      reg_block_pkg::ALU_SLT:   return {{(DWIDTH-1){1'b0}}, (a < b)};
      reg_block_pkg::ALU_SLTU:  return {{(DWIDTH-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      reg_block_pkg::ALU_PASSB: return b;
      default:                  return '0;
    endcase
  endfunction

  reg_file #(
    .AW (RWIDTH),
    .DW (DWIDTH)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra      (rs),
    .rb      (rt),
    .wa      (rd),
    .wd      (wd),
    .we      (we),
    .rdata_a (op_a),
    .rdata_b (rt_data)
  );

  assign imm_ext   = sign_ext(imm_in);
  assign op_b      = muxsel1 ? imm_ext : rt_data;
  assign opBwd     = rt_data;
  assign ALUresult = alu(ALUopsel, op_a, op_b);

endmodule

// File: tb/tb_reg_block.sv
// Bench for reg_block: directed scenarios plus random traffic against an array-based reference model.
module tb_reg_block;
  import reg_block_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [RWIDTH-1:0] rs, rt, rd;
  logic [DWIDTH-1:0] wd;
  logic              we, muxsel1;
  logic [IMM_IN-1:0] imm_in;
  logic [3:0]        ALUopsel;
  logic [DWIDTH-1:0] opBwd, ALUresult;

  int total = 0;
  int bad   = 0;
  bit [31:0] mdl [64];

  reg_block dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .wd        (wd),
    .we        (we),
    .muxsel1   (muxsel1),
    .imm_in    (imm_in),
    .ALUopsel  (ALUopsel),
    .opBwd     (opBwd),
    .ALUresult (ALUresult)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] ref_alu(input int op, input bit [31:0] a, input bit [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return a << sh;
      7:  return a >> sh;
      8:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      9:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      10: return (a < b) ? 32'd1 : 32'd0;
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit [31:0] ref_opb();
    bit [31:0] imm;
    imm = {17'd0, imm_in};
    if (imm_in[14]) imm = imm - 32'h8000;
    return muxsel1 ? imm : mdl[rt];
  endfunction

  // Model commits on the edge from the inputs present just before it.
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
    end else if (we && rd != 0) begin
      mdl[rd] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    #1;
    check({tag, "_opbwd"}, opBwd, mdl[rt]);
    check({tag, "_alu"}, ALUresult, ref_alu(int'(ALUopsel), mdl[rs], ref_opb()));
  endtask

  localparam int NOPS = 8;
  int          op_tab  [NOPS] = '{1, 2, 6, 7, 8, 9, 10, 13};
  logic [31:0] exp_tab [NOPS] = '{32'h7FFFFFFD, 32'h0, 32'h10, 32'h08000000,
                                  32'hF8000000, 32'h1, 32'h0, 32'h0};

  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = $urandom;
    rst_n = 1'b0; rs = 6'd35; rt = 6'd41; rd = 6'd7; wd = 32'h12345678; we = 1'b1;
    muxsel1 = 1'b0; imm_in = '0; ALUopsel = 4'd0;
    @(negedge clk);
    tick();
    tick();
    we = 1'b0;
    #1;
    check("reset_alu", ALUresult, 32'h0);
    check("reset_opbwd", opBwd, 32'h0);
    rst_n = 1'b1;

    rs = 6'd0; rt = 6'd41; muxsel1 = 1'b1; imm_in = 15'h1FFF; #1;
    check("imm_pos", ALUresult, 32'h00001FFF);
    check("imm_pos_opbwd", opBwd, 32'h0);
    imm_in = 15'h4000; #1;
    check("imm_neg", ALUresult, 32'hFFFFC000);
    check("imm_neg_opbwd", opBwd, 32'h0);

    we = 1'b1; rd = 6'd63; wd = 32'hFFAAFFAA; rs = 6'd63; rt = 6'd63; muxsel1 = 1'b0; #1;
    check("pre_edge_alu", ALUresult, 32'h0);
    check("pre_edge_opbwd", opBwd, 32'h0);
    tick();
    we = 1'b0; rt = 6'd0; #1;
    check("wr_rd_alu", ALUresult, 32'hFFAAFFAA);
    rt = 6'd63; #1;
    check("wr_rd_opbwd", opBwd, 32'hFFAAFFAA);

    we = 1'b1; rd = 6'd0; wd = 32'hBBBBBBBB;
    tick();
    we = 1'b0; rs = 6'd0; rt = 6'd0; #1;
    check("r0_alu", ALUresult, 32'h0);
    check("r0_opbwd", opBwd, 32'h0);

    we = 1'b1; rd = 6'd1; wd = 32'h80000001; tick();
    rd = 6'd2; wd = 32'h00000004; tick();
    we = 1'b0; rs = 6'd1; rt = 6'd2; muxsel1 = 1'b0;
    for (int i = 0; i < NOPS; i++) begin
      ALUopsel = 4'(op_tab[i]); #1;
      check($sformatf("aluop%0d", op_tab[i]), ALUresult, exp_tab[i]);
    end

    // Glitching rst_n between edges must leave state alone.
    @(negedge clk);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tick();
    rs = 6'd63; ALUopsel = 4'd0; rt = 6'd0; #1;
    check("rst_glitch_r63", ALUresult, 32'hFFAAFFAA);

    rst_n = 1'b0; we = 1'b1; rd = 6'd5; wd = 32'h1;
    tick();
    rst_n = 1'b1; we = 1'b0; rs = 6'd63; rt = 6'd5; #1;
    check("midrst_r63", ALUresult, 32'h0);
    check("midrst_r5", opBwd, 32'h0);

    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      we       = $urandom_range(0, 1);
      rd       = 6'($urandom_range(0, 63));
      wd       = $urandom;
      rs       = 6'($urandom_range(0, 63));
      rt       = 6'($urandom_range(0, 63));
      muxsel1  = $urandom_range(0, 1);
      imm_in   = 15'($urandom);
      ALUopsel = 4'($urandom_range(0, 15));
      check_model($sformatf("rnd%0d", n));
      tick();
      check_model($sformatf("rnd%0d_post", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
